// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S capture path.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        CAPTURE,
        PAUSED,
        FULL
    } cap_state_t;

    localparam int CH_LEFT   = 0;
    localparam int CH_RIGHT  = 1;
    localparam int CH_STEREO = 2;

    function automatic longint unsigned addr_max(input int unsigned aw);
        return (64'd1 << aw) - 64'd1;
    endfunction

endpackage

// File: rtl/aud_i2s_deser.sv
// I2S slot deserialiser: MSB sampled one cycle after an lrc edge, word_valid after the LSB.
// No backpressure; a new edge before the LSB drops the partial word and flags short_err.
module aud_i2s_deser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lrc,
    input  logic              data,
    input  logic              arm,
    output logic              slot_start,
    output logic [DATA_W-1:0] word,
    output logic              channel,
    output logic              word_valid,
    output logic              short_err
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          lrc_q;
    logic [CW-1:0] bits_left;

    assign slot_start = (lrc != lrc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lrc_q      <= lrc;
            bits_left  <= '0;
            word       <= '0;
            channel    <= 1'b0;
            word_valid <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            lrc_q      <= lrc;
            word_valid <= 1'b0;
            short_err  <= 1'b0;
            if (!arm) begin
                bits_left <= '0;
            end else begin
                if (bits_left != '0) begin
                    word <= {word[DATA_W-2:0], data};
                    if (bits_left == CNT_ONE)
                        word_valid <= 1'b1;
                end
                // An edge coinciding with the LSB still completes the word (back-to-back slots).
                if (slot_start) begin
                    short_err <= (bits_left > CNT_ONE);
                    bits_left <= CNT_LOAD;
                    channel   <= lrc;
                end else if (bits_left != '0) begin
                    bits_left <= bits_left - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/aud_i2s_capture.sv
// I2S ADC capture to SRAM: o_wr at lrc edge + DATA_W + 1, counters advance one cycle later.
// No backpressure on the SRAM port; stop > pause > start, with stereo rollback on pause.
module aud_i2s_capture
    import aud_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int CH_MODE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_length,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_err
);

    localparam logic              MONO      = (CH_MODE == CH_LEFT) || (CH_MODE == CH_RIGHT);
    localparam logic              STEREO    = (CH_MODE == CH_STEREO);
    localparam logic              SYNC_LRC  = (CH_MODE == CH_RIGHT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(addr_max(ADDR_W));
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

    cap_state_t        state, next_state;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W:0]   len, len_nxt;
    logic              slot_start, sync_hit, arm, take, last_wr;
    logic [DATA_W-1:0] w_word;
    logic              w_chan, w_valid;

    aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
        .clk        (i_clk),
        .rst        (i_rst),
        .lrc        (i_lrc),
        .data       (i_data),
        .arm        (arm),
        .slot_start (slot_start),
        .word       (w_word),
        .channel    (w_chan),
        .word_valid (w_valid),
        .short_err  (o_err)
    );

    // Stereo and left-only both sync on the falling edge; right-only on the rising edge.
    assign sync_hit = slot_start && (i_lrc == SYNC_LRC);
    assign last_wr  = o_wr && (addr == ADDR_LAST);
    assign arm      = !i_stop && !i_pause &&
                      ((state == CAPTURE) || ((state == WAIT_SYNC) && sync_hit));
    assign take     = w_valid && (state == CAPTURE) && !i_stop && !i_pause && !last_wr &&
                      (!MONO || (w_chan == SYNC_LRC));

    always_comb begin
        next_state = state;
        addr_nxt   = o_wr ? addr + ADDR_ONE : addr;
        len_nxt    = o_wr ? len + LEN_ONE : len;
        if ((state == WAIT_SYNC) && sync_hit)
            next_state = CAPTURE;
        if (i_stop) begin
            next_state = IDLE;
        end else if (last_wr) begin
            next_state = FULL;
        end else if (i_pause) begin
            if ((state == WAIT_SYNC) || (state == CAPTURE)) begin
                next_state = PAUSED;
                // Drop an orphaned left word so resume rewrites the pair from its left slot.
                if (STEREO && addr_nxt[0]) begin
                    addr_nxt = addr_nxt - ADDR_ONE;
                    len_nxt  = len_nxt - LEN_ONE;
                end
            end
        end else if (i_start) begin
            if ((state == IDLE) || (state == FULL)) begin
                next_state = WAIT_SYNC;
                addr_nxt   = '0;
                len_nxt    = '0;
            end else if (state == PAUSED) begin
                next_state = WAIT_SYNC;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            addr   <= '0;
            len    <= '0;
            o_wr   <= 1'b0;
            o_data <= '0;
            o_busy <= 1'b0;
            o_full <= 1'b0;
        end else begin
            state  <= next_state;
            addr   <= addr_nxt;
            len    <= len_nxt;
            o_wr   <= take;
            if (take)
                o_data <= w_word;
            o_busy <= (next_state == WAIT_SYNC) || (next_state == CAPTURE);
            o_full <= (next_state == FULL);
        end
    end

    assign o_address = addr;
    assign o_length  = len;

endmodule

// File: tb/tb_aud_i2s_capture.sv
// Directed bench: a stereo instance (ADDR_W=3) and a left-only instance (ADDR_W=4) share one I2S stream.
module tb_aud_i2s_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lrc = 1'b1;
    logic sdat = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop = 1'b0;

    always #5 clk = ~clk;

    logic        wr, busy, full, err;
    logic [2:0]  address;
    logic [15:0] wdata;
    logic [3:0]  length;
    logic        wr_l, busy_l, full_l, err_l;
    logic [3:0]  address_l;
    logic [15:0] wdata_l;
    logic [4:0]  length_l;

    aud_i2s_capture #(.DATA_W(16), .ADDR_W(3), .CH_MODE(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(sdat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_wr(wr), .o_address(address), .o_data(wdata), .o_length(length),
        .o_busy(busy), .o_full(full), .o_err(err)
    );

    aud_i2s_capture #(.DATA_W(16), .ADDR_W(4), .CH_MODE(0)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(sdat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_wr(wr_l), .o_address(address_l), .o_data(wdata_l), .o_length(length_l),
        .o_busy(busy_l), .o_full(full_l), .o_err(err_l)
    );

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] dat;
    } wr_t;

    typedef struct {
        logic        ch;
        logic [15:0] w;
        int          half;
        int          act_k;
        int          act;     // 0 none, 1 pause at act_k, 2 reset at act_k
        int          n;
        int          addr;
        int          len;
        logic        full;
        int          n_l;
        int          addr_l;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_e = 0;
    int   errl_n = 0;
    wr_t  wq[$];
    wr_t  wql[$];
    int   errq[$];
    int   eq[$];
    vec_t tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr)    wq.push_back('{cyc, int'(address), wdata});
        if (wr_l)  wql.push_back('{cyc, int'(address_l), wdata_l});
        if (err)   errq.push_back(cyc);
        if (err_l) errl_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic ch, input logic [15:0] w, input int half, act_k, act,
                       n, addr, len, input logic fl, input int n_l, addr_l);
        vec_t v;
        v.ch = ch; v.w = w; v.half = half; v.act_k = act_k; v.act = act;
        v.n = n; v.addr = addr; v.len = len; v.full = fl; v.n_l = n_l; v.addr_l = addr_l;
        tbl.push_back(v);
    endtask

    task automatic ctl(input logic st, input logic pa, input logic sp);
        @(negedge clk);
        start = st; pause = pa; stop = sp;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    // One lrc half-period of n cycles; the edge is seen at the posedge after k=0.
    task automatic slot(input logic ch, input logic [15:0] w, input int n, input int act_k,
                        input int act);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (act == 2 && k == act_k + 1) begin
                chk("rst_wr", wr, 0);
                chk("rst_address", address, 0);
                chk("rst_data", wdata, 0);
                chk("rst_length", length, 0);
                chk("rst_busy", busy, 0);
                chk("rst_full", full, 0);
                chk("rst_err", err, 0);
                chk("rst_length_l", length_l, 0);
            end
            if (k == 0) begin
                lrc = ch;
                last_e = cyc + 1;
                eq.push_back(last_e);
            end
            sdat  = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            pause = (act == 1 && k == act_k);
            rst   = (act == 2 && k == act_k);
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wq.delete();
            wql.delete();
            slot(tbl[i].ch, tbl[i].w, tbl[i].half, tbl[i].act_k, tbl[i].act);
            chk($sformatf("row%0d wr_count", i), wq.size(), tbl[i].n);
            if (tbl[i].n == 1 && wq.size() == 1) begin
                chk($sformatf("row%0d addr", i), wq[0].addr, tbl[i].addr);
                chk($sformatf("row%0d data", i), wq[0].dat, tbl[i].w);
                chk($sformatf("row%0d latency", i), wq[0].cyc - last_e, 17);
            end
            chk($sformatf("row%0d length", i), length, tbl[i].len);
            chk($sformatf("row%0d full", i), full, tbl[i].full);
            chk($sformatf("row%0d wr_count_l", i), wql.size(), tbl[i].n_l);
            if (tbl[i].n_l == 1 && wql.size() == 1) begin
                chk($sformatf("row%0d addr_l", i), wql[0].addr, tbl[i].addr_l);
                chk($sformatf("row%0d data_l", i), wql[0].dat, tbl[i].w);
            end
        end
    endtask

    initial begin
        // ch, word, half, act_k, act, n, addr, len, full, n_l, addr_l
        add(0, 16'h8888, 36, 0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 16'h1234, 36, 0, 0, 1, 1, 2, 0, 0, 0);
        add(0, 16'hF0E1, 36, 0, 0, 1, 2, 3, 0, 1, 1);
        add(1, 16'h5555, 36, 0, 0, 1, 3, 4, 0, 0, 0);
        add(0, 16'hD2C3, 36, 0, 0, 1, 4, 5, 0, 1, 2);
        add(1, 16'h7777, 36, 0, 0, 1, 5, 6, 0, 0, 0);
        add(0, 16'hB4A5, 36, 0, 0, 1, 6, 7, 0, 1, 3);
        add(1, 16'h0F0F, 36, 0, 0, 1, 7, 8, 1, 0, 0);
        add(0, 16'h1111, 36, 0, 0, 0, 0, 8, 1, 1, 4);
        add(1, 16'h9999, 36, 0, 0, 0, 0, 0, 0, 0, 0);   // 9: restart after full
        add(0, 16'hAAAA, 36, 0, 0, 1, 0, 1, 0, 1, 5);
        add(1, 16'hBBBB, 36, 0, 0, 1, 1, 2, 0, 0, 0);
        add(0, 16'hCCCC, 36, 0, 0, 1, 2, 3, 0, 1, 6);
        add(1, 16'h3C3C, 36, 8, 1, 0, 0, 2, 0, 0, 0);   // 13: pause mid right slot
        add(0, 16'hDDDD, 36, 0, 0, 1, 2, 3, 0, 1, 7);
        add(1, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);   // 15..20: short slots
        add(0, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'hFFFF, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 16'h0000, 36, 0, 0, 0, 0, 0, 0, 0, 0);   // 21
        add(0, 16'hEEEE, 36, 0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 16'h6666, 36, 8, 2, 0, 0, 0, 0, 0, 0);   // 23: reset at E+8
        add(0, 16'h1357, 36, 0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 16'h2468, 36, 0, 0, 1, 1, 2, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_wr", wr, 0);
        chk("reset_address", address, 0);
        chk("reset_data", wdata, 0);
        chk("reset_length", length, 0);
        chk("reset_busy", busy, 0);
        chk("reset_full", full, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;

        ctl(1, 0, 0);
        chk("start_busy", busy, 1);
        chk("start_busy_l", busy_l, 1);
        apply_rows(0, 8);

        ctl(1, 0, 0);
        chk("refill_full", full, 0);
        chk("refill_length", length, 0);
        chk("refill_address", address, 0);
        chk("refill_busy", busy, 1);
        chk("start_ignored_busy_l", busy_l, 1);
        apply_rows(9, 13);
        chk("pause_address", address, 2);
        chk("pause_busy", busy, 0);
        chk("pause_length_l", length_l, 7);

        ctl(1, 0, 0);
        chk("resume_busy", busy, 1);
        apply_rows(14, 14);

        ctl(0, 0, 1);
        chk("stop_busy", busy, 0);
        chk("stop_length_held", length, 3);
        chk("stop_busy_l", busy_l, 0);

        ctl(1, 0, 0);
        errq.delete();
        eq.delete();
        errl_n = 0;
        apply_rows(15, 20);
        chk("short_err_count", errq.size(), 4);
        chk("short_err_count_l", errl_n, 4);
        chk("short_err_first_cycle", (errq.size() > 0) ? errq[0] : -1, (eq.size() > 2) ? eq[2] : -2);

        ctl(0, 0, 1);
        ctl(1, 0, 1);
        chk("start_stop_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("start_stop_busy_later", busy, 0);
        chk("start_stop_busy_l", busy_l, 0);

        ctl(1, 0, 0);
        apply_rows(21, 23);
        ctl(1, 0, 0);
        apply_rows(24, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aud_i2s_capture.md
Name: aud_i2s_capture

Overview:
Parametrised successor of the single-channel audio recorder. Deserialises I2S ADC data clocked by the audio bit clock and writes samples to SRAM. Sample width, address width and channel mode (left, right, stereo-interleaved) are configurable. Adds a full flag, a framing-error flag, a stored-length output and deterministic pause/stop/start arbitration. Sits between the WM8731 ADC pins and the SRAM write port, alongside the player path.

Parameters:
DATA_W, 16, sample width in bits (4..32)
ADDR_W, 20, SRAM word-address width
CH_MODE, 2, 0 = left only, 1 = right only, 2 = stereo (left at even address, right at odd)

Ports:
i_clk  in  1  audio bit clock (BCLK); sole clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_lrc  in  1  ADC LR clock; low = left, high = right
i_data  in  1  ADC serial data, MSB first, I2S one-bit delay
i_start  in  1  start or resume capture (level, sampled every cycle)
i_pause  in  1  pause capture
i_stop  in  1  stop capture
o_wr  out  1  SRAM write strobe, one-cycle pulse
o_address  out  ADDR_W  write address, valid with o_wr
o_data  out  DATA_W  write data, valid with o_wr
o_length  out  ADDR_W+1  number of words stored since the last start from IDLE/FULL
o_busy  out  1  high in WAIT_SYNC or CAPTURE
o_full  out  1  memory full
o_err  out  1  one-cycle pulse on a short (truncated) channel slot

Behaviour:
- Reset (any state, mid-word included): all outputs 0, state IDLE, address counter 0, shift register cleared, lrc history register set to the current i_lrc value.
- Edge: cycle E where i_lrc differs from its registered copy. The slot channel is the new i_lrc level. MSB is sampled at E+1, LSB at E+DATA_W.
- o_wr pulses at E+DATA_W+1, carrying o_data and o_address. The address counter and o_length increment on the following edge.
- A new lrc edge before the LSB is sampled discards the partial word and pulses o_err at that edge cycle. Bits after the LSB within a slot are ignored.
- Mode filter: CH_MODE 0/1 write only the matching channel. CH_MODE 2 writes both.
- States:
  - IDLE: start -> WAIT_SYNC; address and o_length cleared to 0.
  - WAIT_SYNC: waits for a slot-start edge. Stereo waits for a falling edge (left slot). Mono waits for the edge of the selected channel. Then -> CAPTURE, with the deserialiser armed from that edge.
  - CAPTURE: writes as above.
  - PAUSED: start -> WAIT_SYNC; address is kept.
  - FULL: start -> WAIT_SYNC with address cleared; stop -> IDLE.
- Priority for same-cycle requests: stop > pause > start. Requests are evaluated every cycle.
- Stop from WAIT_SYNC, CAPTURE or PAUSED -> IDLE. Any partial word is discarded. o_length holds its value.
- Pause from WAIT_SYNC or CAPTURE -> PAUSED. Any partial word is discarded.
- Stereo pause with an odd address (left written, right not): the address counter and o_length decrement by 1, so the orphaned left word is overwritten on resume.
- A write at address 2^ADDR_W-1 moves to FULL next cycle with o_full=1. No further o_wr is issued. o_length = 2^ADDR_W.
- Start while already in WAIT_SYNC or CAPTURE is ignored.
- o_busy and o_full are registered and decode the current state.

Decomposition:
- Package aud_pkg:
  - typedef enum cap_state_t {IDLE, WAIT_SYNC, CAPTURE, PAUSED, FULL}
  - localparams CH_LEFT=0, CH_RIGHT=1, CH_STEREO=2
  - function addr_max(ADDR_W)
- Sub-module aud_i2s_deser #(DATA_W):
  - Inputs: lrc edge detect, shift register, bit counter, arm.
  - Outputs: word, channel, word_valid, short_err.
- Top level holds the FSM, mode filter, address/length counters and pause rollback.

Test Plan:
1. Stereo, DATA_W=16, lrc half-period 36 cycles, left 16'h8888, right 16'h1234, start pulse -> o_wr at E+17 with (addr 0, 8888), then (addr 1, 1234). o_length=2 after the second write.
2. CH_MODE=0, left slots 16'hF0E1/16'hD2C3/16'hB4A5 with right slots of non-zero data -> writes only F0E1@0, D2C3@1, B4A5@2. No write during right slots.
3. Stereo pause mid-right-slot after left written at addr 2 -> PAUSED with o_address/o_length=2. Start -> next left word written at addr 2.
4. ADDR_W=3, stereo -> after 8 writes o_full=1, o_length=8, no 9th o_wr. Start -> next write at addr 0.
5. lrc half-period 10 with DATA_W=16 -> o_err pulse at every edge, zero o_wr. Start+stop in the same cycle from IDLE -> stays IDLE, o_busy=0.
6. i_rst asserted at E+8 of a slot -> all outputs 0 the next cycle. Subsequent start captures cleanly from addr 0.
